univ_shift_register: RTL

UNIV_SHIFT_REGISTER -- requirements
Module: univ_shift_register

---
 rtl/univ_shift_pkg.sv | 35 +++
 rtl/shift_step.sv | 49 ++++
 rtl/univ_shift_register.sv | 106 ++++++++++
 3 files changed

// File: rtl/univ_shift_pkg.sv
// Shared mode/state encodings for the universal shift register.
// Rotate modes (ROTL/ROTR) exist only when USHIFT_ROTATE_EN is defined.
package univ_shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_SHL  = 3'd1,
        MODE_SHR  = 3'd2,
        MODE_ASR  = 3'd3,
        MODE_ROTL = 3'd4,
        MODE_ROTR = 3'd5,
        MODE_RSV6 = 3'd6,
        MODE_RSV7 = 3'd7
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // True for modes whose step discards a bit and therefore updates sout.
    function automatic logic mode_moves_bits(input mode_e m);
        logic moves;
        moves = 1'b0;
        case (m)
            MODE_SHL, MODE_SHR, MODE_ASR: moves = 1'b1;
`ifdef USHIFT_ROTATE_EN
            MODE_ROTL, MODE_ROTR:         moves = 1'b1;
`endif
            default:                      moves = 1'b0;
        endcase
        return moves;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit step of the universal shift register (purely combinational).
// Rotate modes are built only with USHIFT_ROTATE_EN; otherwise they hold.
module shift_step
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        case (mode)
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], sin_l};
                out_bit = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next  = {sin_r, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ASR: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
`ifdef USHIFT_ROTATE_EN
            MODE_ROTL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            MODE_ROTR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
`endif
            default: begin
                q_next  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_register.sv
// Universal shift register: parallel load plus multi-step shifts run one bit per cycle.
// Define USHIFT_ROTATE_EN to enable the rotate modes (they hold otherwise).
module univ_shift_register
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_q;
    logic             step_out;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q       (q_q),
        .mode    (mode_q),
        .sin_l   (sin_l),
        .sin_r   (sin_r),
        .q_next  (step_q),
        .out_bit (step_out)
    );

    // Inputs are only looked at in IDLE; a run uses the latched mode and
    // count, while the serial inputs are sampled live at every step edge.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    q_d = d;
                end else if (start) begin
                    if (amount == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        mode_d  = mode_e'(mode);
                        cnt_d   = amount;
                    end
                end
            end
            ST_RUN: begin
                q_d   = step_q;
                cnt_d = cnt_q - CNT_W'(1);
                if (mode_moves_bits(mode_q)) begin
                    sout_d = step_out;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            cnt_q   <= '0;
            q_q     <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = (state_q == ST_RUN);
    assign done = done_q;

endmodule
